// File: rtl/fetch_pkg.sv
// fetch_pkg
// Shared constants and types for the prefetching fetch unit.
//   PC_STEP            - byte distance between sequential instructions
//   DEFAULT_HALT_MASK  - bits of an instruction compared for halt detection
//   DEFAULT_HALT_VALUE - halt pattern after masking
//   fetch_entry_t      - one prefetch queue entry {instr, pc_plus4} at the
//                        default 32-bit widths
package fetch_pkg;

  localparam int          PC_STEP            = 4;
  localparam int          FETCH_ADDR_W       = 32;
  localparam int          FETCH_INSTR_W      = 32;
  localparam logic [31:0] DEFAULT_HALT_MASK  = 32'h0000_0FFF;
  localparam logic [31:0] DEFAULT_HALT_VALUE = 32'h0000_0300;

  typedef struct packed {
    logic [FETCH_INSTR_W-1:0] instr;
    logic [FETCH_ADDR_W-1:0]  pc_plus4;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_prefetch_queue_if.sv
// fetch_prefetch_queue_if
// Bundles the instruction-memory read port, the decode handshake and the
// redirect input of the fetch unit.
//   master : the fetch unit (drives imem_req/imem_addr and the decode head)
//   slave  : the environment (memory, decode, branch resolution)
// Signals:
//   imem_req, imem_addr  - read request and address (current PC)
//   imem_rdata           - read data, valid the cycle after imem_req
//   inst_valid/ready     - decode handshake on the queue head
//   inst, inst_pc_plus4  - head instruction and its PC+4
//   redirect, redirect_target - resolved taken branch/jump from ID
interface fetch_prefetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
);

  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               inst_valid;
  logic               inst_ready;
  logic [INSTR_W-1:0] inst;
  logic [ADDR_W-1:0]  inst_pc_plus4;
  logic               redirect;
  logic [ADDR_W-1:0]  redirect_target;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc_plus4,
    input  imem_rdata, inst_ready, redirect, redirect_target
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc_plus4,
    output imem_rdata, inst_ready, redirect, redirect_target
  );

endinterface

// File: rtl/fetch_queue.sv
// fetch_queue
// Synchronous DEPTH-entry FIFO holding prefetched instructions.
//   clk, reset      - clock, synchronous active-high reset
//   flush           - empties the queue; wins over push and pop
//   push, push_data - write one entry (accepted when not full, or when a
//                     pop happens in the same cycle)
//   pop             - drop the head entry (ignored when empty)
//   head            - current head entry (don't-care when count == 0)
//   count           - number of valid entries, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   push,
  input  entry_t                 push_data,
  input  logic                   pop,
  output entry_t                 head,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [DEPTH];
  entry_t             mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               do_push, do_pop;

  always_comb begin
    do_pop   = pop && (count_q != '0) && !flush;
    do_push  = push && !flush && ((count_q != CNT_W'(DEPTH)) || do_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  // storage stage: data array is not reset, only the bookkeeping is
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/fetch_prefetch_queue.sv
// fetch_prefetch_queue
// Fetch unit with a prefetch queue. Owns the PC, issues sequential reads to
// a 1-cycle-latency instruction memory, buffers {word, PC+4} in a DEPTH-entry
// queue and presents the head to decode with valid/ready. A redirect from ID
// reloads the PC and flushes everything fetched so far. A halt word stops
// further requests once fetched and raises the sticky end_program when it is
// consumed by decode.
// Ports:
//   clk, reset     - clock, synchronous active-high reset
//   start_address  - PC loaded on reset
//   bus            - fetch_prefetch_queue_if.master (memory port, decode
//                    handshake, redirect)
//   end_program    - halt instruction consumed; sticky until reset
//   perf_fetched, perf_flushed, perf_stall - only when FETCH_PERF_EN is
//                    defined: saturating 32-bit counters of pushes, entries
//                    discarded by redirect, and decode stall cycles
// Configuration macro: FETCH_PERF_EN
module fetch_prefetch_queue
  import fetch_pkg::*;
#(
  parameter int                 ADDR_W     = 32,
  parameter int                 INSTR_W    = 32,
  parameter int                 DEPTH      = 4,
  parameter logic [INSTR_W-1:0] HALT_MASK  = DEFAULT_HALT_MASK,
  parameter logic [INSTR_W-1:0] HALT_VALUE = DEFAULT_HALT_VALUE
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     start_address,
  fetch_prefetch_queue_if.master bus,
  output logic                  end_program
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_flushed,
  output logic [31:0]           perf_stall
`endif
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  pc_plus4;
  } entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return (word & HALT_MASK) == HALT_VALUE;
  endfunction

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] issue_pc4_q, issue_pc4_d;
  logic              inflight_q, inflight_d;
  logic              squash_q, squash_d;
  logic              halt_seen_q, halt_seen_d;
  logic              end_program_q, end_program_d;

  logic [CNT_W-1:0]  q_count;
  logic [CNT_W:0]    occupancy;
  logic              credit;
  logic              req, push, pop, inst_valid;
  logic [ADDR_W-1:0] pc_next;
  entry_t            push_entry, head;

  always_comb begin
    pc_next    = pc_q + ADDR_W'(PC_STEP);
    // Words already requested count against the queue, so a response can
    // never arrive to a full queue; a same-cycle pop is not credited.
    occupancy  = {1'b0, q_count} + {{CNT_W{1'b0}}, inflight_q};
    credit     = occupancy < (CNT_W + 1)'(DEPTH);
    req        = !reset && !bus.redirect && !halt_seen_q && !end_program_q && credit;
    inst_valid = !reset && (q_count != '0) && !end_program_q;
    pop        = inst_valid && bus.inst_ready && !bus.redirect;
    push       = inflight_q && !squash_q && !bus.redirect;

    push_entry.instr    = bus.imem_rdata;
    push_entry.pc_plus4 = issue_pc4_q;

    pc_d          = pc_q;
    issue_pc4_d   = issue_pc4_q;
    inflight_d    = req;
    squash_d      = bus.redirect;
    halt_seen_d   = halt_seen_q;
    end_program_d = end_program_q;

    if (bus.redirect) begin
      pc_d        = bus.redirect_target;
      halt_seen_d = 1'b0;
    end else begin
      if (req) begin
        pc_d        = pc_next;
        issue_pc4_d = pc_next;
      end
      if (push && is_halt(bus.imem_rdata)) begin
        halt_seen_d = 1'b1;
      end
      if (pop && is_halt(head.instr)) begin
        end_program_d = 1'b1;
      end
    end
  end

  // request stage: PC and in-flight tracking
  always_ff @(posedge clk) begin
    issue_pc4_q <= issue_pc4_d;
    if (reset) begin
      pc_q          <= start_address;
      inflight_q    <= 1'b0;
      squash_q      <= 1'b0;
      halt_seen_q   <= 1'b0;
      end_program_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      squash_q      <= squash_d;
      halt_seen_q   <= halt_seen_d;
      end_program_q <= end_program_d;
    end
  end

  // response stage: returned words enter the prefetch queue
  fetch_queue #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_queue (
    .clk       (clk),
    .reset     (reset),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head),
    .count     (q_count)
  );

  assign bus.imem_req      = req;
  assign bus.imem_addr     = pc_q;
  assign bus.inst_valid    = inst_valid;
  assign bus.inst          = head.instr;
  assign bus.inst_pc_plus4 = head.pc_plus4;
  assign end_program       = end_program_q;

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? '1 : sum[31:0];
  endfunction

  logic [31:0] perf_fetched_q, perf_fetched_d;
  logic [31:0] perf_flushed_q, perf_flushed_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_fetched_d = sat_add(perf_fetched_q, 32'(push));
    perf_flushed_d = perf_flushed_q;
    if (bus.redirect) begin
      perf_flushed_d = sat_add(perf_flushed_q,
                               32'(q_count) + 32'(inflight_q && !squash_q));
    end
    perf_stall_d = sat_add(perf_stall_q, 32'(inst_valid && !bus.inst_ready));
  end

  // counter stage
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_flushed_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_flushed_q <= perf_flushed_d;
      perf_stall_q   <= perf_stall_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_flushed = perf_flushed_q;
  assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_prefetch_queue.sv
// tb_fetch_prefetch_queue
// Directed scenarios followed by randomized traffic. A transaction-level
// model (PC, one outstanding-read flag, a queue of {word, pc+4}) predicts
// every output each cycle; literal expectations pin the key timings.
module tb_fetch_prefetch_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] start_address = 32'h100;
  logic        end_program;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_flushed, perf_stall;
`endif

  fetch_prefetch_queue_if #(.ADDR_W(32), .INSTR_W(32)) bus ();

  fetch_prefetch_queue #(.ADDR_W(32), .INSTR_W(32), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .reset         (reset),
    .start_address (start_address),
    .bus           (bus),
    .end_program   (end_program)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_flushed  (perf_flushed),
    .perf_stall    (perf_stall)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // memory contents: low byte 0x13 never matches the halt pattern, except
  // at halt_addr which holds the halt word
  logic [31:0] halt_addr = 32'hFFFF_FFFF;
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == halt_addr) return 32'h0000_0300;
    return {a[23:0] ^ 24'h5A_C3_96, 8'h13};
  endfunction

  function automatic logic is_halt(input logic [31:0] w);
    return (w & 32'h0000_0FFF) == 32'h0000_0300;
  endfunction

  // behavioural model
  typedef struct { logic [31:0] instr; logic [31:0] pc4; } ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc;
  logic        m_infl;
  logic [31:0] m_infl_pc4;
  logic        m_halt, m_endp;
  logic [31:0] m_fetched, m_flushed, m_stall;

  // last sampled DUT outputs
  logic        s_req, s_valid, s_endp;
  logic [31:0] s_addr, s_inst, s_pc4;
  logic        prev_req = 1'b0;
  logic [31:0] prev_addr = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input logic rst_i, input logic redir, input logic [31:0] tgt,
                      input logic rdy);
    logic        e_req, e_valid, e_pop;
    ent_t        h;
    @(negedge clk);
    reset               = rst_i;
    bus.redirect        = redir;
    bus.redirect_target = tgt;
    bus.inst_ready      = rdy;
    bus.imem_rdata      = prev_req ? mem_word(prev_addr) : $urandom;
    #1;
    s_req   = bus.imem_req;
    s_addr  = bus.imem_addr;
    s_valid = bus.inst_valid;
    s_inst  = bus.inst;
    s_pc4   = bus.inst_pc_plus4;
    s_endp  = end_program;

    e_req   = !rst_i && !redir && !m_halt && !m_endp && ((mq.size() + int'(m_infl)) < DEPTH);
    e_valid = !rst_i && (mq.size() != 0) && !m_endp;
    if (!rst_i) begin
      chk("imem_req", 32'(s_req), 32'(e_req));
      if (e_req) chk("imem_addr", s_addr, m_pc);
      chk("inst_valid", 32'(s_valid), 32'(e_valid));
      if (e_valid) begin
        chk("inst", s_inst, mq[0].instr);
        chk("inst_pc_plus4", s_pc4, mq[0].pc4);
      end
      chk("end_program", 32'(s_endp), 32'(m_endp));
`ifdef FETCH_PERF_EN
      chk("perf_fetched", perf_fetched, m_fetched);
      chk("perf_flushed", perf_flushed, m_flushed);
      chk("perf_stall", perf_stall, m_stall);
`endif
    end
    prev_req  = s_req;
    prev_addr = s_addr;

    if (rst_i) begin
      mq.delete();
      m_pc = start_address; m_infl = 0; m_infl_pc4 = '0;
      m_halt = 0; m_endp = 0;
      m_fetched = 0; m_flushed = 0; m_stall = 0;
    end else begin
      if (e_valid && !rdy) m_stall++;
      if (redir) begin
        m_flushed += 32'(mq.size()) + 32'(m_infl);
        mq.delete();
        m_pc = tgt; m_halt = 0; m_infl = 0;
      end else begin
        e_pop = e_valid && rdy;
        if (e_pop) begin
          h = mq.pop_front();
          if (is_halt(h.instr)) m_endp = 1;
        end
        if (m_infl) begin
          mq.push_back('{instr: bus.imem_rdata, pc4: m_infl_pc4});
          m_fetched++;
          if (is_halt(bus.imem_rdata)) m_halt = 1;
        end
        m_infl = e_req;
        if (e_req) begin
          m_infl_pc4 = m_pc + 32'd4;
          m_pc       = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    int          nreq, endp_cyc;
    logic [31:0] maxaddr, next_pc4;
    logic        rdy, redir, rst_i;
    logic [31:0] tgt;
    bus.redirect = 0; bus.redirect_target = '0; bus.inst_ready = 0; bus.imem_rdata = '0;

    // A: sequential fetch after reset
    start_address = 32'h100;
    step(1, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("A_req0", 32'(s_req), 1);
    chk("A_addr0", s_addr, 32'h100);
    chk("A_valid0", 32'(s_valid), 0);
    chk("A_endp0", 32'(s_endp), 0);
    step(0, 0, 0, 1);
    chk("A_addr1", s_addr, 32'h104);
    step(0, 0, 0, 1);
    chk("A_addr2", s_addr, 32'h108);
    chk("A_valid2", 32'(s_valid), 1);
    chk("A_pc4_2", s_pc4, 32'h104);
    chk("A_inst2", s_inst, 32'h5AC2_9613 ^ 32'h0000_0000);

    // B: decode stalled, credit limits requests to DEPTH
    step(1, 0, 0, 0);
    nreq = 0;
    for (int i = 0; i < 8; i++) begin
      step(0, 0, 0, 0);
      nreq += int'(s_req);
    end
    chk("B_reqs", 32'(nreq), 4);
    chk("B_req_stop", 32'(s_req), 0);
    next_pc4 = 32'h104;
    for (int i = 0; i < 14; i++) begin
      step(0, 0, 0, 1);
      if (s_valid) begin
        chk("B_order", s_pc4, next_pc4);
        next_pc4 += 4;
      end
    end

    // C: redirect with 3 queued and 1 in flight
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    step(0, 1, 32'h200, 0);
    step(0, 0, 0, 1);
    chk("C_valid_flushed", 32'(s_valid), 0);
    chk("C_addr_target", s_addr, 32'h200);
    chk("C_req_target", 32'(s_req), 1);
    step(0, 0, 0, 1);
    step(0, 0, 0, 1);
    chk("C_first_valid", 32'(s_valid), 1);
    chk("C_first_pc4", s_pc4, 32'h204);

    // D: halt word at 0x10C
    halt_addr = 32'h10C;
    step(1, 0, 0, 1);
    maxaddr = '0; endp_cyc = -1;
    for (int i = 0; i < 16; i++) begin
      step(0, 0, 0, 1);
      if (s_req && s_addr > maxaddr) maxaddr = s_addr;
      if (s_endp && endp_cyc < 0) endp_cyc = i;
    end
    chk("D_max_addr", maxaddr, 32'h110);
    chk("D_endp_cycle", 32'(endp_cyc), 6);
    chk("D_endp_sticky", 32'(s_endp), 1);
    chk("D_valid_off", 32'(s_valid), 0);

    // E: halt fetched, not popped, then redirect
    halt_addr = 32'h104;
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    chk("E_halt_stop", 32'(s_req), 0);
    step(0, 1, 32'h300, 0);
    step(0, 0, 0, 1);
    chk("E_resume_req", 32'(s_req), 1);
    chk("E_resume_addr", s_addr, 32'h300);
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);
    chk("E_endp_clear", 32'(s_endp), 0);
    chk("E_valid", 32'(s_valid), 1);
    halt_addr = 32'hFFFF_FFFF;

    // F: reset with a full queue
    start_address = 32'h100;
    step(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 0);
    chk("F_full_valid", 32'(s_valid), 1);
    start_address = 32'h400;
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("F_valid", 32'(s_valid), 0);
    chk("F_req", 32'(s_req), 1);
    chk("F_addr", s_addr, 32'h400);
`ifdef FETCH_PERF_EN
    chk("F_perf_fetched", perf_fetched, 0);
    chk("F_perf_flushed", perf_flushed, 0);
    chk("F_perf_stall", perf_stall, 0);
`endif

    // G: randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      redir = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 9) < 7);
      tgt   = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFF0
                                           : {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if ($urandom_range(0, 49) == 0)
        halt_addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (rst_i) start_address = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      step(rst_i, redir, tgt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
